program_counter: RTL and testbench



---
 rtl/program_counter.sv | 76 +++++++
 tb/tb_program_counter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Instruction-address register for the K2 core.
//
// Advances by one slot per clock, wraps from the last slot back to zero, and
// loads an absolute immediate target when a jump is requested. The registered
// output indexes instruction memory.
//
// Ports:
//   clk_i       system clock; all state changes on the rising edge
//   reset_i     synchronous active-high reset; forces the counter to zero
//   data_i      datapath value reserved for future conditional branches;
//               has no effect in this revision
//   jump_i      1 = load jump_imm_i this cycle, 0 = sequential advance
//   jump_imm_i  absolute jump target address
//   counter_o   current program counter (registered)
module program_counter #(
  parameter int unsigned N                    = 8,
  parameter int unsigned INSTRUCTIONS         = 9,
  parameter int unsigned JUMP_BITS            = 3,
  localparam int unsigned INSTRUCTIONS_BITS   = $clog2(INSTRUCTIONS)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [N-1:0]                 data_i,
  input  logic                         jump_i,
  input  logic [JUMP_BITS-1:0]         jump_imm_i,
  output logic [INSTRUCTIONS_BITS-1:0] counter_o
);

  typedef logic [INSTRUCTIONS_BITS-1:0] cnt_t;

  // Highest legal address; anything above it is out of range.
  localparam cnt_t LastAddr = cnt_t'(INSTRUCTIONS - 1);

  // Elaboration-time parameter sanity checks.
  if (INSTRUCTIONS < 2) begin : gen_bad_instructions
    $error("program_counter: INSTRUCTIONS must be at least 2");
  end
  if (JUMP_BITS > INSTRUCTIONS_BITS) begin : gen_bad_jump_bits
    $error("program_counter: jump target wider than the counter");
  end

  cnt_t counter_q, counter_d;
  cnt_t jump_tgt;
  logic jump_in_range;
  logic seq_in_range;

  // data_i is deliberately unused; fold it into a sink so it stays visible.
  logic unused_data;
  assign unused_data = ^data_i;

  assign jump_tgt      = cnt_t'(jump_imm_i);
  assign jump_in_range = (jump_tgt <= LastAddr);
  // Strictly below the last slot: increments; at or above it (including
  // corrupted values) the counter returns to zero.
  assign seq_in_range  = (counter_q < LastAddr);

  always_comb begin
    counter_d = '0;
    if (jump_i) begin
      counter_d = jump_in_range ? jump_tgt : '0;
    end else if (seq_in_range) begin
      counter_d = counter_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      counter_q <= '0;
    end else begin
      counter_q <= counter_d;
    end
  end

  assign counter_o = counter_q;

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;

  logic       clk;
  logic       reset;
  logic [7:0] data;
  logic       jump;
  logic [2:0] jump_imm;
  logic [3:0] counter;

  // Small instance (5 slots) makes the out-of-range jump path reachable.
  logic       s_reset;
  logic [3:0] s_data;
  logic       s_jump;
  logic [2:0] s_jump_imm;
  logic [2:0] s_counter;

  int n_tests = 0;
  int n_fail  = 0;

  program_counter dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .data_i     (data),
    .jump_i     (jump),
    .jump_imm_i (jump_imm),
    .counter_o  (counter)
  );

  program_counter #(
    .N            (4),
    .INSTRUCTIONS (5),
    .JUMP_BITS    (3)
  ) dut_small (
    .clk_i      (clk),
    .reset_i    (s_reset),
    .data_i     (s_data),
    .jump_i     (s_jump),
    .jump_imm_i (s_jump_imm),
    .counter_o  (s_counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       jmp;
    logic [2:0] imm;
    logic [7:0] dat;
    int         exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic j, input logic [2:0] i, input logic [7:0] d);
    @(negedge clk);
    reset    = r;
    jump     = j;
    jump_imm = i;
    data     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step_s(input logic r, input logic j, input logic [2:0] i, input int exp,
                        input string name);
    @(negedge clk);
    s_reset    = r;
    s_jump     = j;
    s_jump_imm = i;
    s_data     = 4'hA;
    @(posedge clk);
    #1;
    check(name, int'(s_counter), exp);
  endtask

  function automatic vec_t v(logic r, logic j, logic [2:0] i, logic [7:0] d, int e);
    vec_t t;
    t.rst = r; t.jmp = j; t.imm = i; t.dat = d; t.exp = e;
    return t;
  endfunction

  logic [7:0] dpat[4];

  initial begin
    reset = 1'b1; jump = 1'b0; jump_imm = '0; data = '0;
    s_reset = 1'b1; s_jump = 1'b0; s_jump_imm = '0; s_data = '0;

    // Reset wins over jump, then sequential advance.
    vecs.push_back(v(1, 1, 3'd5, 8'h00, 0));
    vecs.push_back(v(0, 0, 3'd0, 8'h00, 1));
    vecs.push_back(v(0, 0, 3'd0, 8'h00, 2));
    vecs.push_back(v(0, 0, 3'd0, 8'h00, 3));
    // Wrap: 1..8, 0, then 1.
    vecs.push_back(v(1, 0, 3'd0, 8'h00, 0));
    for (int k = 1; k <= 10; k++) vecs.push_back(v(0, 0, 3'd0, 8'h00, k % 9));
    // Jump loads, consecutive jumps, wrap after jump.
    vecs.push_back(v(0, 1, 3'd4, 8'h00, 4));
    vecs.push_back(v(0, 1, 3'd5, 8'h00, 5));
    vecs.push_back(v(0, 1, 3'd7, 8'h00, 7));
    vecs.push_back(v(0, 0, 3'd0, 8'h00, 8));
    vecs.push_back(v(0, 0, 3'd0, 8'h00, 0));
    // Jump to current address holds.
    vecs.push_back(v(0, 1, 3'd4, 8'h00, 4));
    vecs.push_back(v(0, 1, 3'd4, 8'h00, 4));
    vecs.push_back(v(0, 1, 3'd3, 8'h00, 3));
    vecs.push_back(v(0, 0, 3'd0, 8'h00, 4));
    vecs.push_back(v(0, 0, 3'd0, 8'h00, 5));
    vecs.push_back(v(0, 0, 3'd0, 8'h00, 6));
    // Mid-run reset.
    vecs.push_back(v(1, 0, 3'd0, 8'h00, 0));
    vecs.push_back(v(0, 0, 3'd0, 8'h00, 1));

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].jmp, vecs[k].imm, vecs[k].dat);
      check($sformatf("vec%0d", k), int'(counter), vecs[k].exp);
    end

    // Data independence: identical sequence for every data pattern.
    dpat[0] = 8'h00; dpat[1] = 8'h01; dpat[2] = 8'hFF; dpat[3] = 8'hA5;
    for (int p = 0; p < 4; p++) begin
      step(1, 0, 3'd0, dpat[p]); check($sformatf("data%0d_rst", p), int'(counter), 0);
      step(0, 0, 3'd0, dpat[p]); check($sformatf("data%0d_s1", p), int'(counter), 1);
      step(0, 0, 3'd0, dpat[p]); check($sformatf("data%0d_s2", p), int'(counter), 2);
      step(0, 1, 3'd6, dpat[p]); check($sformatf("data%0d_j6", p), int'(counter), 6);
      step(0, 0, 3'd0, dpat[p]); check($sformatf("data%0d_s7", p), int'(counter), 7);
      step(0, 0, 3'd0, dpat[p]); check($sformatf("data%0d_s8", p), int'(counter), 8);
      step(0, 0, 3'd0, dpat[p]); check($sformatf("data%0d_wrap", p), int'(counter), 0);
    end
    reset = 1'b1;

    // Small instance: wrap at 4 and out-of-range jump targets go to zero.
    step_s(1, 1, 3'd3, 0, "small_rst");
    step_s(0, 0, 3'd0, 1, "small_s1");
    step_s(0, 0, 3'd0, 2, "small_s2");
    step_s(0, 0, 3'd0, 3, "small_s3");
    step_s(0, 0, 3'd0, 4, "small_s4");
    step_s(0, 0, 3'd0, 0, "small_wrap");
    step_s(0, 1, 3'd4, 4, "small_j4");
    step_s(0, 1, 3'd6, 0, "small_j6_oor");
    step_s(0, 1, 3'd2, 2, "small_j2");
    step_s(0, 1, 3'd5, 0, "small_j5_oor");
    step_s(0, 1, 3'd7, 0, "small_j7_oor");
    step_s(0, 0, 3'd0, 1, "small_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
